dmem_mmio: RTL and testbench

Data-memory responder for the rv32i core's data port: the core drives the store/load address, mode, and store data, and this block returns load data. It holds a byte-addressed RAM and a small memory-mapped I/O window containing a cycle counter, a transmit byte FIFO with a ready/valid drain port, a status register, and a halt register. Loads are answered combinationally in the same cycle as the core's M stage. Stores commit on the clock edge.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/tx_byte_fifo.sv | 60 ++++++
 rtl/dmem_mmio.sv | 158 +++++++++++++++
 tb/tb_dmem_mmio.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the rv32i data-memory responder: MMIO register
// indices, store-mode encodings and STATUS bit positions.
package dmem_pkg;

  // MMIO register index taken from address bits [3:2]
  typedef enum logic [1:0] {
    REG_CYCLE  = 2'd0,
    REG_TXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_HALT   = 2'd3
  } mmio_reg_e;

  // Store size encodings driven on mode
  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_HALF = 2'b01,
    MODE_WORD = 2'b10,
    MODE_RSVD = 2'b11
  } store_mode_e;

  // STATUS register bit positions
  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;

endpackage

// File: rtl/tx_byte_fifo.sv
// Transmit byte FIFO; owns push/pop/full arbitration. A push while full is
// accepted only when a pop happens in the same cycle.
module tx_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  // Accept/pop arbitration and flag decode
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = empty ? 8'h00 : mem[rd_ptr];
  end

  // Pointer, occupancy and storage update
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory responder: byte-addressed RAM plus a 16-byte MMIO window
// (cycle counter, TX byte FIFO, status, halt). Loads are combinational,
// stores commit on the clock edge.
// Build option: DMEM_CYCLE_CNT_EN builds the CYCLE counter; without it
// CYCLE reads 0 and writes to it are ignored.
import dmem_pkg::*;

module dmem_mmio #(
  parameter int unsigned        ADDR_W     = 8,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  MMIO_BASE  = 8'hF0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              halt,
  output logic [7:0]        halt_code
);

  localparam int unsigned NBYTES   = DATA_W / 8;
  localparam int unsigned RAM_SIZE = 1 << ADDR_W;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);

  logic [7:0]        ram [RAM_SIZE];
  logic [DATA_W-1:0] ram_word;
  logic [DATA_W-1:0] mmio_word;
  logic [DATA_W-1:0] cycle;
  logic [2:0]        st_bytes;
  logic              ram_we;
  logic              mmio_we;
  mmio_reg_e         wr_reg;
  logic              tx_we;
  logic              status_we;
  logic              halt_we;
  logic              pop_eff;
  logic              ovf;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_head;

  // Store decode: RAM vs MMIO target and byte count
  always_comb begin
    mmio_we   = wr_en && (wr_addr >= MMIO_BASE);
    ram_we    = wr_en && (wr_addr < MMIO_BASE);
    wr_reg    = mmio_reg_e'(wr_addr[3:2]);
    tx_we     = mmio_we && (wr_reg == REG_TXDATA);
    status_we = mmio_we && (wr_reg == REG_STATUS);
    halt_we   = mmio_we && (wr_reg == REG_HALT);
    case (mode)
      MODE_BYTE: st_bytes = 3'd1;
      MODE_HALF: st_bytes = 3'd2;
      MODE_WORD: st_bytes = 3'd4;
      default:   st_bytes = 3'd0;
    endcase
  end

  // RAM byte writes; spill-over bytes wrap and always hit backing RAM
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (3'(i) < st_bytes) begin
          ram[ADDR_W'(wr_addr + ADDR_W'(i))] <= d_in[8*i +: 8];
        end
      end
    end
  end

  // Little-endian RAM read of the addressed byte and the following ones
  always_comb begin
    ram_word = '0;
    for (int i = 0; i < NBYTES; i++) begin
      ram_word[8*i +: 8] = ram[ADDR_W'(rd_addr + ADDR_W'(i))];
    end
  end

`ifdef DMEM_CYCLE_CNT_EN
  logic cycle_we;
  assign cycle_we = mmio_we && (wr_reg == REG_CYCLE);

  // Free-running cycle counter; a write loads d_in in place of the increment
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cycle <= '0;
    end else if (cycle_we) begin
      cycle <= d_in;
    end else begin
      cycle <= DATA_W'(cycle + DATA_W'(1));
    end
  end
`else
  assign cycle = '0;
`endif

  assign pop_eff = !fifo_empty && out_ready;

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (tx_we),
    .push_data (d_in[7:0]),
    .pop       (out_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky overflow flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ovf <= 1'b0;
    end else if (tx_we && fifo_full && !pop_eff) begin
      ovf <= 1'b1;
    end else if (status_we && d_in[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  // Halt request: first HALT write latches the code, later ones are ignored
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      halt      <= 1'b0;
      halt_code <= 8'h00;
    end else if (halt_we && !halt) begin
      halt      <= 1'b1;
      halt_code <= d_in[7:0];
    end
  end

  // MMIO read mux; reads never change state
  always_comb begin
    mmio_word = '0;
    case (mmio_reg_e'(rd_addr[3:2]))
      REG_CYCLE:  mmio_word = cycle;
      REG_TXDATA: mmio_word = '0;
      REG_STATUS: mmio_word = DATA_W'({ST_CNT_W'(fifo_count), 1'b0, ovf, fifo_full, fifo_empty});
      REG_HALT:   mmio_word = DATA_W'({halt, halt_code});
      default:    mmio_word = '0;
    endcase
  end

  assign d_out     = (rd_addr >= MMIO_BASE) ? mmio_word : ram_word;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus queues expected values, a monitor
// on the falling edge pops and compares load data, flags and drained bytes.
module tb_dmem_mmio;

  localparam int K_DOUT  = 0;
  localparam int K_VLD   = 1;
  localparam int K_HALT  = 2;
  localparam int K_ODATA = 3;

`ifdef DMEM_CYCLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [31:0] exp;
    logic [31:0] mask;
    string       nm;
  } chk_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        wr_en;
  logic [1:0]  mode;
  logic [7:0]  wr_addr;
  logic [7:0]  rd_addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        halt;
  logic [7:0]  halt_code;

  int   total = 0;
  int   bad   = 0;
  chk_t cq[$];
  logic [7:0] tq[$];
  logic chk = 1'b0;

  always #5 clk = ~clk;

  dmem_mmio dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .wr_en     (wr_en),
    .mode      (mode),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .d_in      (d_in),
    .d_out     (d_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halt      (halt),
    .halt_code (halt_code)
  );

  // Monitor: compare queued checks and every accepted FIFO beat
  chk_t        mc;
  logic [31:0] act;
  logic [7:0]  texp;
  always @(negedge clk) begin
    if (chk) begin
      while (cq.size() > 0) begin
        mc = cq.pop_front();
        case (mc.kind)
          K_VLD:   act = 32'(out_valid);
          K_HALT:  act = 32'({halt, halt_code});
          K_ODATA: act = 32'(out_data);
          default: act = d_out;
        endcase
        total++;
        if ((act & mc.mask) !== mc.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", mc.nm, act & mc.mask, mc.exp);
        end
      end
    end
    if (n_rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (tq.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got %h want no beat", out_data);
      end else begin
        texp = tq.pop_front();
        if (out_data !== texp) begin
          bad++;
          $display("FAIL tx_beat: got %h want %h", out_data, texp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input int k, input logic [31:0] e, input logic [31:0] m, input string nm);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.mask = m;
    c.nm   = nm;
    cq.push_back(c);
  endtask

  // One clock cycle with every queued check evaluated in it
  task automatic cyc();
    chk = 1'b1;
    tick();
    chk = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input logic [31:0] m, input string nm);
    rd_addr = a;
    want(K_DOUT, e, m, nm);
    cyc();
  endtask

  task automatic st(input logic [7:0] a, input logic [1:0] md, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    mode    = md;
    d_in    = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; wr_en = 1'b0; mode = 2'b00; wr_addr = 8'h00;
    rd_addr = 8'h00; d_in = 32'h0; out_ready = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;

    // Reset state
    want(K_VLD, 32'h0, 32'hFFFFFFFF, "rst_valid");
    want(K_HALT, 32'h0, 32'hFFFFFFFF, "rst_halt");
    want(K_ODATA, 32'h0, 32'hFFFFFFFF, "rst_odata");
    rd(8'hF8, 32'h1, 32'hFFFFFFFF, "rst_status");

    // RAM word store and misaligned load
    st(8'h10, 2'b10, 32'h11223344);
    rd(8'h10, 32'h11223344, 32'hFFFFFFFF, "ram_word");
    rd(8'h11, 32'h33, 32'hFF, "ram_misaligned");

    // Same-cycle load sees old data; byte/half/reserved stores
    st(8'h20, 2'b10, 32'h01020304);
    rd_addr = 8'h20;
    want(K_DOUT, 32'h01020304, 32'hFFFFFFFF, "ram_old_data");
    st(8'h20, 2'b00, 32'hAABBCC99);
    rd(8'h20, 32'h01020399, 32'hFFFFFFFF, "ram_byte_store");
    st(8'h21, 2'b01, 32'h1234BEEF);
    rd(8'h20, 32'h01BEEF99, 32'hFFFFFFFF, "ram_half_store");
    st(8'h20, 2'b11, 32'hFFFFFFFF);
    rd(8'h20, 32'h01BEEF99, 32'hFFFFFFFF, "ram_rsvd_store");

    // Half store spilling into backing RAM under the MMIO window
    st(8'hEF, 2'b01, 32'h0000BEEF);
    rd(8'hEF, 32'h0000BEEF, 32'hFFFF, "ram_spill");

    // CYCLE write (mode and low address bits ignored) then wrap
    st(8'hF1, 2'b00, 32'hFFFFFFFE);
    rd(8'hF0, CNT_ON ? 32'hFFFFFFFE : 32'h0, 32'hFFFFFFFF, "cycle_t1");
    rd(8'hF0, CNT_ON ? 32'hFFFFFFFF : 32'h0, 32'hFFFFFFFF, "cycle_t2");
    rd(8'hF0, 32'h0, 32'hFFFFFFFF, "cycle_wrap");

    // Fill FIFO, overflow with a fifth byte
    tq.push_back(8'h41);
    st(8'hF4, 2'b00, 32'h41);
    want(K_VLD, 32'h1, 32'hFFFFFFFF, "push_valid");
    want(K_ODATA, 32'h41, 32'hFFFFFFFF, "push_head");
    rd(8'hF4, 32'h0, 32'hFFFFFFFF, "txdata_read");
    for (int i = 2; i <= 5; i++) begin
      if (i <= 4) tq.push_back(8'(8'h40 + i));
      st(8'hF4, 2'b00, 32'(32'h40 + i));
    end
    rd(8'hF8, 32'h46, 32'hFFFFFFFF, "status_ovf");
    st(8'hF8, 2'b00, 32'h4);
    rd(8'hF8, 32'h42, 32'hFFFFFFFF, "status_clr");

    // Push and pop together while full
    out_ready = 1'b1;
    tq.push_back(8'h46);
    st(8'hF4, 2'b00, 32'h46);
    out_ready = 1'b0;
    rd(8'hF8, 32'h42, 32'hFFFFFFFF, "status_pushpop_full");

    // Drain everything, bounded
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    want(K_VLD, 32'h0, 32'hFFFFFFFF, "drained_valid");
    rd(8'hF8, 32'h1, 32'hFFFFFFFF, "drained_status");
    total++;
    if (tq.size() != 0) begin
      bad++;
      $display("FAIL tx_left: got %0d want 0", tq.size());
    end

    // Push into empty FIFO while consumer ready: only the push happens
    tq.push_back(8'h50);
    st(8'hF4, 2'b00, 32'h50);
    want(K_VLD, 32'h1, 32'hFFFFFFFF, "empty_push_valid");
    cyc();
    want(K_VLD, 32'h0, 32'hFFFFFFFF, "empty_push_gone");
    cyc();
    out_ready = 1'b0;

    // Halt is sticky
    st(8'hFC, 2'b00, 32'h5A);
    want(K_HALT, 32'h15A, 32'hFFFFFFFF, "halt_set");
    rd(8'hFC, 32'h15A, 32'hFFFFFFFF, "halt_read");
    st(8'hFD, 2'b00, 32'h00);
    want(K_HALT, 32'h15A, 32'hFFFFFFFF, "halt_sticky");
    cyc();

    // Reset discards FIFO and halt, keeps RAM
    st(8'hF4, 2'b00, 32'h60);
    st(8'hF4, 2'b00, 32'h61);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    want(K_HALT, 32'h0, 32'hFFFFFFFF, "rst2_halt");
    want(K_VLD, 32'h0, 32'hFFFFFFFF, "rst2_valid");
    want(K_ODATA, 32'h0, 32'hFFFFFFFF, "rst2_odata");
    rd(8'hF0, 32'h0, 32'hFFFFFFFF, "rst2_cycle");
    rd(8'hF8, 32'h1, 32'hFFFFFFFF, "rst2_status");
    rd(8'h10, 32'h11223344, 32'hFFFFFFFF, "rst2_ram");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
